// File: rtl/regbus_arbiter.sv
// -----------------------------------------------------------------------------
// regbus_arbiter
//   Shares the internal register bus between two command masters
//   (m0 = host AXI-lite bridge, m1 = on-board sequencing logic). Commands are
//   accepted with round-robin arbitration. One bus transaction is issued at a
//   time. Read data and an acknowledge go back to the master that issued it.
//
// Optional feature (macro REGBUS_TIMEOUT_EN):
//   When defined, a bus wait that lasts TIMEOUT_CYCLES cycles completes with
//   err=1. A read that times out returns 32'hDEAD_BEEF.
//   When undefined, the block waits for bus_ready indefinitely and the err
//   outputs are tied to 0.
//
// Ports:
//   axi_aclk, axi_areset      clock, synchronous active-high reset
//   mN_valid / mN_ready       command handshake (ready is combinational, IDLE only)
//   mN_we, mN_addr, mN_wdata  command payload
//   mN_ack, mN_rdata, mN_err  completion pulse, held read data, timeout flag
//   addressbus, databus_out   latched bus address / write data (0 in IDLE)
//   databus_in, bus_ready     target read data and completion
//   readsignal, writesignal   one-cycle bus strobes
// -----------------------------------------------------------------------------
module regbus_arbiter #(
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,

  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              m1_err,

  output logic [AWIDTH-1:0] addressbus,
  output logic [DWIDTH-1:0] databus_out,
  input  logic [DWIDTH-1:0] databus_in,
  output logic              readsignal,
  output logic              writesignal,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  state_e              state_q, state_d;
  logic                owner_q;     // 0 = m0, 1 = m1
  logic                we_q;
  logic                rr_q;        // master granted last time
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   rdata0_q, rdata1_q;

  logic                gnt0_c, gnt1_c;
  logic                accept_c;
  logic                busy_c;
  logic                finish_c;
  logic                timeout_hit_c;

  // On a tie the master not granted last time wins.
  assign gnt0_c   = m0_valid && (!m1_valid || rr_q);
  assign gnt1_c   = m1_valid && (!m0_valid || !rr_q);
  assign accept_c = (state_q == S_IDLE) && !axi_areset && (gnt0_c || gnt1_c);
  assign busy_c   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  // bus_ready wins over a timeout reached in the same cycle.
  assign finish_c = busy_c && (bus_ready || timeout_hit_c);

`ifdef REGBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q;
  logic             err0_q, err1_q;

  // The limit is reached on the cycle whose increment would make cnt hit it.
  assign timeout_hit_c = busy_c && !bus_ready &&
                         ((17'({1'b0, cnt_q}) + 17'd1) == 17'(TIMEOUT_CYCLES));

  // Wait counter: cleared on acceptance, counts ISSUE/WAIT cycles without bus_ready.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= '0;
    end else if (busy_c && !bus_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Error flags, updated with the owner's completion and held until its next one.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else if (finish_c) begin
      if (!owner_q) err0_q <= !bus_ready;
      else          err1_q <= !bus_ready;
    end
  end

  assign m0_err = err0_q;
  assign m1_err = err1_q;
`else
  logic unused_timeout_cfg;

  // The timeout limit only matters when the timeout logic is built in.
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit_c      = 1'b0;
  assign m0_err             = 1'b0;
  assign m1_err             = 1'b0;
`endif

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_ISSUE;
      S_ISSUE: state_d = finish_c ? S_DONE : S_WAIT;
      S_WAIT:  if (finish_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    readsignal  = 1'b0;
    writesignal = 1'b0;
    addressbus  = '0;
    databus_out = '0;
    if (!axi_areset) begin
      case (state_q)
        S_IDLE: begin
          m0_ready = gnt0_c;
          m1_ready = gnt1_c;
        end
        S_ISSUE: begin
          readsignal  = !we_q;
          writesignal = we_q;
          addressbus  = addr_q;
          databus_out = wdata_q;
        end
        S_WAIT: begin
          addressbus  = addr_q;
          databus_out = wdata_q;
        end
        S_DONE: begin
          m0_ack      = !owner_q;
          m1_ack      = owner_q;
          addressbus  = addr_q;
          databus_out = wdata_q;
        end
        default: ;
      endcase
    end
  end

  // Command latch, round-robin pointer and per-master read data.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rr_q     <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept_c) begin
        owner_q <= gnt1_c;
        we_q    <= gnt1_c ? m1_we    : m0_we;
        addr_q  <= gnt1_c ? m1_addr  : m0_addr;
        wdata_q <= gnt1_c ? m1_wdata : m0_wdata;
      end
      // Read data lands on the edge into DONE so it is valid alongside ack.
      if (finish_c && !we_q) begin
        if (!owner_q) rdata0_q <= bus_ready ? databus_in : DWIDTH'(TIMEOUT_RDATA);
        else          rdata1_q <= bus_ready ? databus_in : DWIDTH'(TIMEOUT_RDATA);
      end
      if (state_q == S_DONE) rr_q <= owner_q;
    end
  end

  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbus_arbiter
//   Self-checking bench for regbus_arbiter. A transaction-level model keeps the
//   pending command of each master, the last granted master and the held
//   read data / error of each master. Each transaction is checked cycle by
//   cycle against timing derived from the bus_ready delay chosen by the bench.
//   Build with +define+REGBUS_TIMEOUT_EN to also exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_regbus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef REGBUS_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_ready, m0_we, m0_ack, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_we, m1_ack, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] addressbus;
  logic [DW-1:0] databus_out, databus_in;
  logic          readsignal, writesignal, bus_ready;

  regbus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_ack     (m0_ack),
    .m0_rdata   (m0_rdata),
    .m0_err     (m0_err),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_ack     (m1_ack),
    .m1_rdata   (m1_rdata),
    .m1_err     (m1_err),
    .addressbus (addressbus),
    .databus_out(databus_out),
    .databus_in (databus_in),
    .readsignal (readsignal),
    .writesignal(writesignal),
    .bus_ready  (bus_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state.
  bit          pend_v     [2];
  bit          pend_we    [2];
  logic [31:0] pend_addr  [2];
  logic [31:0] pend_wdata [2];
  logic [31:0] exp_rdata  [2];
  bit          exp_err    [2];
  int unsigned last_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend_v[i]    = 1'b0;
      exp_rdata[i] = '0;
      exp_err[i]   = 1'b0;
    end
    last_grant = 1;
  endtask

  task automatic post_cmd(input int unsigned m, input bit we, input logic [31:0] a, input logic [31:0] d);
    pend_v[m]     = 1'b1;
    pend_we[m]    = we;
    pend_addr[m]  = a;
    pend_wdata[m] = d;
  endtask

  task automatic drive_masters();
    m0_valid = pend_v[0]; m0_we = pend_we[0]; m0_addr = pend_addr[0]; m0_wdata = pend_wdata[0];
    m1_valid = pend_v[1]; m1_we = pend_we[1]; m1_addr = pend_addr[1]; m1_wdata = pend_wdata[1];
  endtask

  // One transaction from an IDLE cycle. dly = strobe-relative cycle on which the
  // bench raises bus_ready; rd_val = data presented on that cycle.
  task automatic run_round(input int unsigned dly, input logic [31:0] rd_val, output int unsigned winner);
    int unsigned exp_w;
    int unsigned last_off;
    bit          timed_out;
    bit          cwe;
    logic [31:0] caddr, cwdata;

    // IDLE: present requests, bus_ready is noise here.
    drive_masters();
    bus_ready  = 1'($urandom_range(0, 1));
    databus_in = $urandom;
    if (pend_v[0] && pend_v[1]) exp_w = 1 - last_grant;
    else if (pend_v[0])         exp_w = 0;
    else                        exp_w = 1;
    @(negedge clk);
    winner = m1_ready ? 1 : 0;
    check_eq("idle_m0_ready", 32'(m0_ready), 32'(exp_w == 0));
    check_eq("idle_m1_ready", 32'(m1_ready), 32'(exp_w == 1));
    check_eq("idle_strobes", 32'({readsignal, writesignal}), 32'(0));
    check_eq("idle_addressbus", addressbus, 32'(0));
    tick();

    cwe    = pend_we[exp_w];
    caddr  = pend_addr[exp_w];
    cwdata = pend_wdata[exp_w];
    pend_v[exp_w] = 1'b0;
    drive_masters();

    timed_out = 1'b0;
    last_off  = dly;
`ifdef REGBUS_TIMEOUT_EN
    if (dly > TO - 1) begin
      timed_out = 1'b1;
      last_off  = TO - 1;
    end
`endif

    // ISSUE (off 0) and WAIT cycles.
    for (int unsigned off = 0; off <= last_off; off++) begin
      bus_ready  = !timed_out && (off == last_off);
      databus_in = bus_ready ? rd_val : $urandom;
      @(negedge clk);
      check_eq("bus_readsignal",  32'(readsignal),  32'(off == 0 && !cwe));
      check_eq("bus_writesignal", 32'(writesignal), 32'(off == 0 && cwe));
      check_eq("bus_addr", addressbus, caddr);
      check_eq("bus_wdata", databus_out, cwdata);
      check_eq("busy_acks", 32'({m0_ack, m1_ack}), 32'(0));
      check_eq("busy_ready", 32'({m0_ready, m1_ready}), 32'(0));
      tick();
    end

    // DONE: bus_ready is ignored again.
    bus_ready  = 1'($urandom_range(0, 1));
    databus_in = $urandom;
    if (!cwe) exp_rdata[exp_w] = timed_out ? 32'hDEAD_BEEF : rd_val;
    exp_err[exp_w] = timed_out;
    last_grant     = exp_w;
    @(negedge clk);
    check_eq("done_m0_ack", 32'(m0_ack), 32'(exp_w == 0));
    check_eq("done_m1_ack", 32'(m1_ack), 32'(exp_w == 1));
    check_eq("done_m0_rdata", m0_rdata, exp_rdata[0]);
    check_eq("done_m1_rdata", m1_rdata, exp_rdata[1]);
    check_eq("done_err", 32'(exp_w == 0 ? m0_err : m1_err), 32'(exp_err[exp_w]));
    check_eq("done_addr", addressbus, caddr);
    check_eq("done_wdata", databus_out, cwdata);
    check_eq("done_strobes", 32'({readsignal, writesignal}), 32'(0));
    tick();
  endtask

  initial begin
    int unsigned w;
    int unsigned dly;

    rst = 1'b1;
    bus_ready = 1'b0;
    databus_in = '0;
    model_reset();
    drive_masters();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", 32'({m0_ready, m1_ready, m0_ack, m1_ack, m0_err, m1_err,
                                   readsignal, writesignal}), 32'(0));
    check_eq("reset_bus", addressbus | databus_out | m0_rdata | m1_rdata, 32'(0));
    tick();

    // Arbitration from reset: both valid, expect m0, m1, m0, m1.
    post_cmd(0, 1'b1, 32'h100, 32'h1111_0000);
    post_cmd(1, 1'b1, 32'h200, 32'h2222_0000);
    run_round(0, 32'h0, w); check_eq("arb_grant0", 32'(w), 32'(0));
    post_cmd(0, 1'b0, 32'h104, 32'h0);
    run_round(1, 32'hCAFE_0001, w); check_eq("arb_grant1", 32'(w), 32'(1));
    post_cmd(1, 1'b0, 32'h204, 32'h0);
    run_round(0, 32'hCAFE_0002, w); check_eq("arb_grant2", 32'(w), 32'(0));
    run_round(2, 32'hCAFE_0003, w); check_eq("arb_grant3", 32'(w), 32'(1));

    // Single read, bus_ready with the strobe.
    post_cmd(0, 1'b0, 32'h10, 32'h0);
    run_round(0, 32'h1234_5678, w);
    check_eq("single_read_rdata", m0_rdata, 32'h1234_5678);

    // Write with a 5-cycle stall; rdata of m1 must not change.
    post_cmd(1, 1'b1, 32'h4, 32'hA5A5_A5A5);
    run_round(5, 32'hFFFF_FFFF, w);
    check_eq("stall_write_grant", 32'(w), 32'(1));

    // Reset while the bus is stalled in WAIT.
    post_cmd(0, 1'b0, 32'h20, 32'h0);
    drive_masters();
    bus_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_accept", 32'(m0_ready), 32'(1));
    tick();
    pend_v[0] = 1'b0;
    drive_masters();
    @(negedge clk);
    check_eq("rst_strobe", 32'(readsignal), 32'(1));
    tick();
    @(negedge clk);
    check_eq("rst_wait_ack", 32'(m0_ack), 32'(0));
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_during_ack", 32'({m0_ack, m1_ack}), 32'(0));
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_after_outputs", 32'({m0_ready, m1_ready, m0_ack, m1_ack, m0_err, m1_err,
                                       readsignal, writesignal}), 32'(0));
    check_eq("rst_after_bus", addressbus | databus_out | m0_rdata | m1_rdata, 32'(0));
    tick();
    check_eq("rst_after_idle_strobe", 32'({readsignal, writesignal}), 32'(0));
    post_cmd(0, 1'b0, 32'h20, 32'h0);
    run_round(1, 32'h0BAD_F00D, w);
    check_eq("rst_next_grant", 32'(w), 32'(0));

`ifdef REGBUS_TIMEOUT_EN
    // Timeout, then a good read clears err, then bus_ready on the limit cycle.
    post_cmd(0, 1'b0, 32'h30, 32'h0);
    run_round(100, 32'h0, w);
    check_eq("timeout_rdata", m0_rdata, 32'hDEAD_BEEF);
    post_cmd(0, 1'b0, 32'h34, 32'h0);
    run_round(0, 32'h5555_AAAA, w);
    check_eq("timeout_clear_err", 32'(m0_err), 32'(0));
    post_cmd(1, 1'b0, 32'h38, 32'h0);
    run_round(TO - 1, 32'h7777_1234, w);
    check_eq("timeout_boundary_rdata", m1_rdata, 32'h7777_1234);
`endif

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend_v[m] && $urandom_range(0, 9) < 6)
          post_cmd(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      if (!pend_v[0] && !pend_v[1])
        post_cmd($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom, $urandom);
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
      run_round(dly, $urandom, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
